lru_repl_ctrl: RTL and testbench

Parametrised true-LRU replacement controller for the set-associative cache. Tracks per-set recency order and per-line valid bits for NUM_SETS x NUM_WAYS lines. On a victim request it returns a registered way index one cycle later. Sits beside the cache controller, which reports hits and fills (touch), invalidations and flushes, and requests a victim on a miss.

---
 rtl/lru_repl_ctrl_if.sv | 35 +++
 rtl/lru_repl_ctrl.sv | 130 +++++++++++++
 tb/tb_lru_repl_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lru_repl_ctrl_if.sv
// Request/response bundle between the cache controller (master) and the LRU
// replacement controller (slave): touch, invalidate, victim request and response.
interface lru_repl_ctrl_if #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 4
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic             touch_valid;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             inv_valid;
  logic [SET_W-1:0] inv_set;
  logic [WAY_W-1:0] inv_way;
  logic             vreq_valid;
  logic [SET_W-1:0] vreq_set;
  logic             vrsp_valid;
  logic [WAY_W-1:0] vrsp_way;
  logic             vrsp_was_valid;

  modport master (
    output touch_valid, touch_set, touch_way,
    output inv_valid, inv_set, inv_way,
    output vreq_valid, vreq_set,
    input  vrsp_valid, vrsp_way, vrsp_was_valid
  );

  modport slave (
    input  touch_valid, touch_set, touch_way,
    input  inv_valid, inv_set, inv_way,
    input  vreq_valid, vreq_set,
    output vrsp_valid, vrsp_way, vrsp_was_valid
  );
endinterface

// File: rtl/lru_repl_ctrl.sv
// True-LRU replacement controller: per-set rank permutation plus line valid bits,
// with a registered victim-way response one cycle after each request.
module lru_repl_ctrl #(
  parameter  int NUM_SETS = 4,
  parameter  int NUM_WAYS = 4,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  lru_repl_ctrl_if.slave               bus,
  input  logic                         flush,
  output logic [NUM_SETS*NUM_WAYS-1:0] valid_out,
  output logic [NUM_SETS-1:0]          set_full
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] set_rank;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            set_valid;

  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
    logic [NUM_WAYS-1:0][WAY_W-1:0] rank_d, rank_q;
    logic [NUM_WAYS-1:0]            valid_d, valid_q;
    logic                           full_q;
    logic                           touch_hit, inv_hit;
    logic [WAY_W-1:0]               ref_rank;

    assign touch_hit = bus.touch_valid && (bus.touch_set == SET_W'(gi));
    assign inv_hit   = bus.inv_valid   && (bus.inv_set   == SET_W'(gi));

    // Touch is applied before invalidate so a same-way pair ends invalid at LRU.
    always_comb begin
      rank_d   = rank_q;
      valid_d  = valid_q;
      ref_rank = '0;
      if (touch_hit) begin
        ref_rank = rank_d[bus.touch_way];
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (rank_d[w] < ref_rank) rank_d[w] = rank_d[w] + WAY_W'(1);
        end
        rank_d[bus.touch_way]  = '0;
        valid_d[bus.touch_way] = 1'b1;
      end
      if (inv_hit) begin
        ref_rank = rank_d[bus.inv_way];
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (rank_d[w] > ref_rank) rank_d[w] = rank_d[w] - WAY_W'(1);
        end
        rank_d[bus.inv_way]  = WAY_W'(NUM_WAYS - 1);
        valid_d[bus.inv_way] = 1'b0;
      end
      if (flush) begin
        for (int w = 0; w < NUM_WAYS; w++) rank_d[w] = WAY_W'(w);
        valid_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int w = 0; w < NUM_WAYS; w++) rank_q[w] <= WAY_W'(w);
        valid_q <= '0;
        full_q  <= 1'b0;
      end else begin
        rank_q  <= rank_d;
        valid_q <= valid_d;
        full_q  <= &valid_d;
      end
    end

    assign set_rank[gi]  = rank_q;
    assign set_valid[gi] = valid_q;
    assign set_full[gi]  = full_q;
  end

  assign valid_out = set_valid;

  logic [NUM_WAYS-1:0][WAY_W-1:0] sel_rank;
  logic [NUM_WAYS-1:0]            sel_valid;
  logic [WAY_W-1:0]               vic_way;
  logic                           vic_inv;

  // Lowest-index invalid way wins; descending scan lets the lowest overwrite last.
  always_comb begin
    sel_rank  = set_rank[bus.vreq_set];
    sel_valid = set_valid[bus.vreq_set];
    vic_way   = '0;
    vic_inv   = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!sel_valid[w]) begin
        vic_way = WAY_W'(w);
        vic_inv = 1'b1;
      end
    end
    if (!vic_inv) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (sel_rank[w] == WAY_W'(NUM_WAYS - 1)) vic_way = WAY_W'(w);
      end
    end
  end

  logic             vrsp_valid_d, vrsp_valid_q;
  logic [WAY_W-1:0] vrsp_way_d, vrsp_way_q;
  logic             vrsp_was_valid_d, vrsp_was_valid_q;

  always_comb begin
    vrsp_valid_d     = bus.vreq_valid;
    vrsp_way_d       = vrsp_way_q;
    vrsp_was_valid_d = vrsp_was_valid_q;
    if (bus.vreq_valid) begin
      vrsp_way_d       = vic_way;
      vrsp_was_valid_d = !vic_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vrsp_valid_q     <= 1'b0;
      vrsp_way_q       <= '0;
      vrsp_was_valid_q <= 1'b0;
    end else begin
      vrsp_valid_q     <= vrsp_valid_d;
      vrsp_way_q       <= vrsp_way_d;
      vrsp_was_valid_q <= vrsp_was_valid_d;
    end
  end

  assign bus.vrsp_valid     = vrsp_valid_q;
  assign bus.vrsp_way       = vrsp_way_q;
  assign bus.vrsp_was_valid = vrsp_was_valid_q;

endmodule

// File: tb/tb_lru_repl_ctrl.sv
// Directed bench for lru_repl_ctrl: expected victim responses are queued when a
// request is driven and compared when the response strobe is due.
module tb_lru_repl_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [15:0] valid_out;
  logic [3:0]  set_full;

  lru_repl_ctrl_if #(.NUM_SETS(4), .NUM_WAYS(4)) bus ();

  lru_repl_ctrl #(.NUM_SETS(4), .NUM_WAYS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flush     (flush),
    .valid_out (valid_out),
    .set_full  (set_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] way;
    logic       wv;
  } exp_t;

  exp_t exp_q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    bus.touch_valid = 1'b0;
    bus.inv_valid   = 1'b0;
    bus.vreq_valid  = 1'b0;
    flush           = 1'b0;
  endtask

  // One clock: inputs were set before the rising edge; outputs checked on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    clear_strobes();
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      $display("rsp valid=%0b way=%0d was_valid=%0b (want way=%0d was_valid=%0b)",
               bus.vrsp_valid, bus.vrsp_way, bus.vrsp_was_valid, e.way, e.wv);
      chk("vrsp_valid", 32'(bus.vrsp_valid), 32'd1);
      chk("vrsp_way", 32'(bus.vrsp_way), 32'(e.way));
      chk("vrsp_was_valid", 32'(bus.vrsp_was_valid), 32'(e.wv));
    end else begin
      chk("vrsp_idle", 32'(bus.vrsp_valid), 32'd0);
    end
  endtask

  task automatic do_touch(input logic [1:0] s, input logic [1:0] w);
    bus.touch_valid = 1'b1;
    bus.touch_set   = s;
    bus.touch_way   = w;
    tick();
  endtask

  task automatic do_inv(input logic [1:0] s, input logic [1:0] w);
    bus.inv_valid = 1'b1;
    bus.inv_set   = s;
    bus.inv_way   = w;
    tick();
  endtask

  task automatic do_vreq(input logic [1:0] s, input logic [1:0] ew, input logic ewv);
    bus.vreq_valid = 1'b1;
    bus.vreq_set   = s;
    exp_q.push_back('{way: ew, wv: ewv});
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.touch_set = '0;
    bus.touch_way = '0;
    bus.inv_set   = '0;
    bus.inv_way   = '0;
    bus.vreq_set  = '0;
    clear_strobes();

    // Reset state
    repeat (3) tick();
    chk("reset_valid_out", 32'(valid_out), 32'h0);
    chk("reset_set_full", 32'(set_full), 32'h0);
    chk("reset_vrsp_way", 32'(bus.vrsp_way), 32'd0);
    chk("reset_vrsp_was_valid", 32'(bus.vrsp_was_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    // Empty sets pick way 0; back-to-back requests
    do_vreq(2'd2, 2'd0, 1'b0);
    do_vreq(2'd0, 2'd0, 1'b0);
    tick();

    // Fill set 1
    for (int w = 0; w < 4; w++) do_touch(2'd1, 2'(w));
    chk("fill1_valid_out", 32'(valid_out), 32'h00F0);
    chk("fill1_set_full", 32'(set_full), 32'b0010);
    do_vreq(2'd1, 2'd0, 1'b1);

    // Touching the LRU advances the victim
    do_touch(2'd1, 2'd0);
    do_vreq(2'd1, 2'd1, 1'b1);
    do_touch(2'd1, 2'd1);
    do_vreq(2'd1, 2'd2, 1'b1);

    // Invalidate in a full set
    do_inv(2'd1, 2'd2);
    chk("inv_set_full", 32'(set_full), 32'b0000);
    chk("inv_valid_out", 32'(valid_out), 32'h00B0);
    do_vreq(2'd1, 2'd2, 1'b0);
    do_touch(2'd1, 2'd2);
    do_vreq(2'd1, 2'd3, 1'b1);
    tick();
    chk("hold_vrsp_way", 32'(bus.vrsp_way), 32'd3);
    chk("hold_vrsp_was_valid", 32'(bus.vrsp_was_valid), 32'd1);

    // Touch and invalidate on different sets in one cycle
    bus.touch_valid = 1'b1; bus.touch_set = 2'd2; bus.touch_way = 2'd1;
    bus.inv_valid   = 1'b1; bus.inv_set   = 2'd1; bus.inv_way   = 2'd0;
    tick();
    chk("split_valid_out", 32'(valid_out), 32'h02E0);
    do_vreq(2'd1, 2'd0, 1'b0);

    // Same-set, same-way touch+inv with a concurrent request
    do_touch(2'd0, 2'd0);
    do_touch(2'd0, 2'd1);
    do_touch(2'd0, 2'd2);
    chk("set0_valid_out", 32'(valid_out), 32'h02E7);
    bus.touch_valid = 1'b1; bus.touch_set = 2'd0; bus.touch_way = 2'd3;
    bus.inv_valid   = 1'b1; bus.inv_set   = 2'd0; bus.inv_way   = 2'd3;
    bus.vreq_valid  = 1'b1; bus.vreq_set  = 2'd0;
    exp_q.push_back('{way: 2'd3, wv: 1'b0});
    tick();
    chk("ti_valid_out", 32'(valid_out), 32'h02E7);
    chk("ti_set_full", 32'(set_full), 32'b0000);
    do_vreq(2'd0, 2'd3, 1'b0);
    do_touch(2'd0, 2'd3);
    chk("ti_refill_full", 32'(set_full), 32'b0001);
    do_vreq(2'd0, 2'd0, 1'b1);

    // Flush with a concurrent request and touch
    for (int w = 0; w < 4; w++) do_touch(2'd3, 2'(w));
    chk("fill3_valid_out", 32'(valid_out), 32'hF2EF);
    chk("fill3_set_full", 32'(set_full), 32'b1001);
    flush           = 1'b1;
    bus.touch_valid = 1'b1; bus.touch_set = 2'd2; bus.touch_way = 2'd0;
    bus.vreq_valid  = 1'b1; bus.vreq_set  = 2'd3;
    exp_q.push_back('{way: 2'd0, wv: 1'b1});
    tick();
    chk("flush_valid_out", 32'(valid_out), 32'h0);
    chk("flush_set_full", 32'(set_full), 32'h0);
    do_vreq(2'd3, 2'd0, 1'b0);

    // Reset during a request drops the response
    do_touch(2'd2, 2'd0);
    do_vreq(2'd2, 2'd1, 1'b0);
    reset_n        = 1'b0;
    bus.vreq_valid = 1'b1;
    bus.vreq_set   = 2'd1;
    tick();
    chk("rst_vrsp_way", 32'(bus.vrsp_way), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
